// File: rtl/laser_host.sv
// LASER host: loads a point frame, streams it to the solver, then scores the
// returned circle centres by counting frame points covered by either circle.
module laser_host #(
  parameter int unsigned NPTS      = 40,
  parameter int unsigned RADIUS_SQ = 16,
  parameter int unsigned TIMEOUT   = 1000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       WR_EN,
  input  logic [5:0] WR_ADDR,
  input  logic [3:0] WR_X,
  input  logic [3:0] WR_Y,
  input  logic       START,
  output logic [3:0] X,
  output logic [3:0] Y,
  input  logic       DONE,
  input  logic [3:0] C1X,
  input  logic [3:0] C1Y,
  input  logic [3:0] C2X,
  input  logic [3:0] C2Y,
  output logic       BUSY,
  output logic [5:0] SCORE,
  output logic       SCORE_VALID,
  output logic       ERR
);

  localparam int unsigned AW = 6;
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned SW = 6;
  localparam logic [AW-1:0] LAST_IDX = AW'(NPTS - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);
  localparam logic [8:0]    RAD_SQ   = 9'(RADIUS_SQ);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_EVAL} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   idx, idx_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [SW-1:0]   acc, acc_nxt, acc_sum;
  logic [3:0]      c1x_q, c1y_q, c2x_q, c2y_q;
  logic [3:0]      c1x_nxt, c1y_nxt, c2x_nxt, c2y_nxt;
  logic [3:0]      x_nxt, y_nxt;
  logic            busy_nxt, sv_nxt, err_nxt;
  logic [SW-1:0]   score_nxt;

  logic [3:0]      mem_x [NPTS];
  logic [3:0]      mem_y [NPTS];
  logic [AW-1:0]   rd_addr;
  logic [3:0]      rd_x, rd_y;
  logic            wr_ok;
  logic            covered;

  // Squared Euclidean distance on 4-bit coordinates; at most 450, fits 9 bits.
  function automatic logic [8:0] dist_sq(input logic [3:0] px, input logic [3:0] py,
                                         input logic [3:0] cx, input logic [3:0] cy);
    logic [3:0] dx, dy;
    logic [7:0] dx2, dy2;
    dx  = (px >= cx) ? (px - cx) : (cx - px);
    dy  = (py >= cy) ? (py - cy) : (cy - py);
    dx2 = 8'(dx) * 8'(dx);
    dy2 = 8'(dy) * 8'(dy);
    return 9'(dx2) + 9'(dy2);
  endfunction

  // Point memory: writable only while idle, never reset.
  assign wr_ok = WR_EN && (state == S_IDLE) && (WR_ADDR < AW'(NPTS));

  always_ff @(posedge CLK) begin
    if (wr_ok) begin
      mem_x[WR_ADDR] <= WR_X;
      mem_y[WR_ADDR] <= WR_Y;
    end
  end

  // SEND registers the next point, so it reads one ahead of the driven index.
  always_comb begin
    rd_addr = '0;
    case (state)
      S_SEND:  rd_addr = (idx == LAST_IDX) ? idx : idx + AW'(1);
      S_EVAL:  rd_addr = idx;
      default: rd_addr = '0;
    endcase
  end

  assign rd_x    = mem_x[rd_addr];
  assign rd_y    = mem_y[rd_addr];
  assign covered = (dist_sq(rd_x, rd_y, c1x_q, c1y_q) <= RAD_SQ) ||
                   (dist_sq(rd_x, rd_y, c2x_q, c2y_q) <= RAD_SQ);
  assign acc_sum = acc + SW'(covered);

  // State and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= S_IDLE;
      idx         <= '0;
      cnt         <= '0;
      acc         <= '0;
      c1x_q       <= '0;
      c1y_q       <= '0;
      c2x_q       <= '0;
      c2y_q       <= '0;
      X           <= '0;
      Y           <= '0;
      BUSY        <= 1'b0;
      SCORE       <= '0;
      SCORE_VALID <= 1'b0;
      ERR         <= 1'b0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      cnt         <= cnt_nxt;
      acc         <= acc_nxt;
      c1x_q       <= c1x_nxt;
      c1y_q       <= c1y_nxt;
      c2x_q       <= c2x_nxt;
      c2y_q       <= c2y_nxt;
      X           <= x_nxt;
      Y           <= y_nxt;
      BUSY        <= busy_nxt;
      SCORE       <= score_nxt;
      SCORE_VALID <= sv_nxt;
      ERR         <= err_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    acc_nxt   = acc;
    c1x_nxt   = c1x_q;
    c1y_nxt   = c1y_q;
    c2x_nxt   = c2x_q;
    c2y_nxt   = c2y_q;
    x_nxt     = '0;
    y_nxt     = '0;
    busy_nxt  = BUSY;
    score_nxt = SCORE;
    sv_nxt    = 1'b0;
    err_nxt   = ERR;

    case (state)
      S_IDLE: begin
        busy_nxt = 1'b0;
        if (START) begin
          state_nxt = S_SEND;
          idx_nxt   = '0;
          x_nxt     = rd_x;
          y_nxt     = rd_y;
          busy_nxt  = 1'b1;
          err_nxt   = 1'b0;
        end
      end

      S_SEND: begin
        if (DONE) err_nxt = 1'b1;
        if (idx == LAST_IDX) begin
          state_nxt = S_WAIT;
          cnt_nxt   = '0;
        end else begin
          idx_nxt = idx + AW'(1);
          x_nxt   = rd_x;
          y_nxt   = rd_y;
        end
      end

      S_WAIT: begin
        // DONE takes priority over an expiring timeout in the same cycle.
        if (DONE) begin
          state_nxt = S_EVAL;
          idx_nxt   = '0;
          acc_nxt   = '0;
          c1x_nxt   = C1X;
          c1y_nxt   = C1Y;
          c2x_nxt   = C2X;
          c2y_nxt   = C2Y;
        end else if (cnt == LAST_CNT) begin
          state_nxt = S_IDLE;
          err_nxt   = 1'b1;
          score_nxt = '0;
          sv_nxt    = 1'b1;
          busy_nxt  = 1'b0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end

      S_EVAL: begin
        acc_nxt = acc_sum;
        if (idx == LAST_IDX) begin
          state_nxt = S_IDLE;
          score_nxt = acc_sum;
          sv_nxt    = 1'b1;
          busy_nxt  = 1'b0;
        end else begin
          idx_nxt = idx + AW'(1);
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_laser_host.sv
// Self-checking bench for laser_host: table-driven frames with a report
// scoreboard, plus timeout, DONE-in-SEND and mid-frame reset sequences.
module tb_laser_host;

  localparam int unsigned NPTS = 40;
  localparam int unsigned TMO  = 100;

  logic       CLK = 1'b0;
  logic       RST, WR_EN, START, DONE;
  logic [5:0] WR_ADDR;
  logic [3:0] WR_X, WR_Y, C1X, C1Y, C2X, C2Y;
  logic [3:0] X, Y;
  logic       BUSY, SCORE_VALID, ERR;
  logic [5:0] SCORE;

  laser_host #(.NPTS(NPTS), .RADIUS_SQ(16), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_X(WR_X), .WR_Y(WR_Y),
    .START(START), .X(X), .Y(Y), .DONE(DONE), .C1X(C1X), .C1Y(C1Y), .C2X(C2X), .C2Y(C2Y),
    .BUSY(BUSY), .SCORE(SCORE), .SCORE_VALID(SCORE_VALID), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [5:0] score;
    logic       err;
  } exp_t;

  typedef struct {
    logic [3:0] ax, ay, bx, by;
    int         na;
    logic [3:0] c1x, c1y, c2x, c2y;
    int         exp_score;
  } frame_t;

  int         checks = 0;
  int         failures = 0;
  exp_t       sb[$];
  logic [3:0] mx [NPTS];
  logic [3:0] my [NPTS];
  frame_t     tbl [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic write_pt(input int a, input logic [3:0] px, input logic [3:0] py);
    WR_EN = 1'b1; WR_ADDR = 6'(a); WR_X = px; WR_Y = py;
    step();
    WR_EN = 1'b0;
    if (a < NPTS) begin
      mx[a] = px;
      my[a] = py;
    end
  endtask

  task automatic load_frame(input frame_t f);
    for (int a = 0; a < NPTS; a++)
      write_pt(a, (a < f.na) ? f.ax : f.bx, (a < f.na) ? f.ay : f.by);
  endtask

  function automatic int model_score(input logic [3:0] c1x, input logic [3:0] c1y,
                                     input logic [3:0] c2x, input logic [3:0] c2y);
    int n, d1, d2;
    n = 0;
    for (int i = 0; i < NPTS; i++) begin
      d1 = (int'(mx[i]) - int'(c1x)) ** 2 + (int'(my[i]) - int'(c1y)) ** 2;
      d2 = (int'(mx[i]) - int'(c2x)) ** 2 + (int'(my[i]) - int'(c2y)) ** 2;
      if (d1 <= 16 || d2 <= 16) n++;
    end
    return n;
  endfunction

  // Wait for a report, pop the scoreboard entry and compare it.
  task automatic await_report(input string tag, input int start_lat, input int exp_lat);
    int   lat;
    bit   got;
    exp_t e;
    lat = start_lat;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      if (SCORE_VALID) got = 1'b1;
      else begin step(); lat++; end
    end
    chk({tag, "_report_seen"}, 32'(got), 1);
    e = sb.pop_front();
    if (got) begin
      chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_score"}, 32'(SCORE), 32'(e.score));
      chk({tag, "_err"}, 32'(ERR), 32'(e.err));
      chk({tag, "_busy_low"}, 32'(BUSY), 0);
      step();
      chk({tag, "_sv_pulse"}, 32'(SCORE_VALID), 0);
      chk({tag, "_score_hold"}, 32'(SCORE), 32'(e.score));
    end
  endtask

  task automatic run_frame(input string tag, input logic [3:0] c1x, input logic [3:0] c1y,
                           input logic [3:0] c2x, input logic [3:0] c2y,
                           input int exp_score, input bit done_in_send);
    exp_t e;
    int   bad;
    START = 1'b1;
    step();
    START = 1'b0;
    chk({tag, "_busy_start"}, 32'(BUSY), 1);
    chk({tag, "_err_start"}, 32'(ERR), 0);
    bad = 0;
    for (int k = 0; k < NPTS; k++) begin
      if (X !== mx[k] || Y !== my[k] || BUSY !== 1'b1) begin
        bad++;
        $display("FAIL %s_stream[%0d]: got (%0d,%0d) expected (%0d,%0d)", tag, k, X, Y, mx[k], my[k]);
      end
      DONE = done_in_send && (k == 10);
      step();
    end
    DONE = 1'b0;
    chk({tag, "_stream_errors"}, 32'(bad), 0);
    chk({tag, "_wait_xy"}, 32'({X, Y}), 0);
    chk({tag, "_err_after_send"}, 32'(ERR), 32'(done_in_send));
    C1X = c1x; C1Y = c1y; C2X = c2x; C2Y = c2y;
    DONE = 1'b1;
    e.score = 6'(exp_score);
    e.err   = done_in_send;
    sb.push_back(e);
    step();
    DONE = 1'b0;
    C1X = '0; C1Y = '0; C2X = '0; C2Y = '0;
    await_report(tag, 1, 41);
  endtask

  initial begin
    exp_t e;
    int   rs;
    logic [3:0] r1x, r1y, r2x, r2y;

    tbl[0] = '{4'd8, 4'd8, 4'd8, 4'd8, 40, 4'd8, 4'd8, 4'd0, 4'd0, 40};
    tbl[1] = '{4'd0, 4'd0, 4'd0, 4'd0, 40, 4'd15, 4'd15, 4'd15, 4'd0, 0};
    tbl[2] = '{4'd8, 4'd12, 4'd11, 4'd11, 20, 4'd8, 4'd8, 4'd0, 4'd15, 20};
    tbl[3] = '{4'd4, 4'd4, 4'd4, 4'd4, 40, 4'd4, 4'd4, 4'd4, 4'd4, 40};
    tbl[4] = '{4'd3, 4'd7, 4'd15, 4'd15, 10, 4'd0, 4'd7, 4'd12, 4'd12, 10};

    RST = 1'b1; WR_EN = 1'b0; WR_ADDR = '0; WR_X = '0; WR_Y = '0;
    START = 1'b0; DONE = 1'b0; C1X = '0; C1Y = '0; C2X = '0; C2Y = '0;
    repeat (3) step();
    chk("reset_xy", 32'({X, Y}), 0);
    chk("reset_busy", 32'(BUSY), 0);
    chk("reset_score", 32'(SCORE), 0);
    chk("reset_sv", 32'(SCORE_VALID), 0);
    chk("reset_err", 32'(ERR), 0);
    RST = 1'b0;
    step();

    for (int f = 0; f < 5; f++) begin
      load_frame(tbl[f]);
      run_frame($sformatf("frame%0d", f), tbl[f].c1x, tbl[f].c1y, tbl[f].c2x, tbl[f].c2y,
                tbl[f].exp_score, 1'b0);
    end

    // Out-of-range writes must not disturb the frame.
    load_frame(tbl[2]);
    write_pt(40, 4'd1, 4'd1);
    write_pt(63, 4'd2, 4'd2);
    run_frame("done_in_send", 4'd8, 4'd8, 4'd0, 4'd15, 20, 1'b1);

    // Timeout: no DONE for TMO cycles after WAIT entry.
    START = 1'b1;
    step();
    START = 1'b0;
    repeat (NPTS) step();
    chk("tmo_in_wait_busy", 32'(BUSY), 1);
    e.score = '0;
    e.err   = 1'b1;
    sb.push_back(e);
    await_report("timeout", 0, TMO);
    DONE = 1'b1;
    step();
    DONE = 1'b0;
    chk("done_idle_err_kept", 32'(ERR), 1);
    chk("done_idle_busy", 32'(BUSY), 0);
    run_frame("after_tmo", 4'd8, 4'd8, 4'd0, 4'd15, 20, 1'b0);

    // Reset during SEND at index 20, with an ignored write earlier in the frame.
    START = 1'b1;
    step();
    START = 1'b0;
    for (int k = 0; k < 20; k++) begin
      WR_EN = (k == 5); WR_ADDR = '0; WR_X = 4'd1; WR_Y = 4'd2;
      step();
    end
    WR_EN = 1'b0;
    chk("rst_idx20_x", 32'(X), 32'(mx[20]));
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("rst_mid_xy", 32'({X, Y}), 0);
    chk("rst_mid_busy", 32'(BUSY), 0);
    chk("rst_mid_sv", 32'(SCORE_VALID), 0);
    chk("rst_mid_err", 32'(ERR), 0);
    step();
    chk("rst_idle_busy", 32'(BUSY), 0);
    run_frame("after_rst", 4'd8, 4'd8, 4'd0, 4'd15, 20, 1'b0);

    // Random frame scored by the bench model.
    for (int a = 0; a < NPTS; a++) write_pt(a, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    r1x = 4'($urandom_range(0, 15)); r1y = 4'($urandom_range(0, 15));
    r2x = 4'($urandom_range(0, 15)); r2y = 4'($urandom_range(0, 15));
    rs = model_score(r1x, r1y, r2x, r2y);
    run_frame("random", r1x, r1y, r2x, r2y, rs, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
